// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Two-requester round-robin arbiter and sequencer for an external 4-bit ALU.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   req{0,1}_valid/a/b/op     requester operations (valid/ready handshake)
//   req{0,1}_ready            combinational accept for the granted requester
//   alu_a, alu_b, alu_op      ALU inputs, driven only during EXEC, else zero
//   alu_out                   combinational ALU result, captured at the end of EXEC
//   rsp_valid/data/id         response channel, held stable until rsp_ready
//   rsp_ready                 consumer accepts the response
//   busy                      high while an operation is in flight (EXEC/RESP)
module alu_share_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       req1_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_out,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] op_a_reg;
  logic [3:0] op_b_reg;
  logic [2:0] op_code_reg;
  logic       cur_id_reg;
  logic       last_id_reg;
  logic [3:0] rsp_data_reg;
  logic       rsp_id_reg;

  logic       grant_valid;
  logic       grant_id;

  // Next-state logic and arbitration
  always_comb begin
    state_next  = state_reg;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          // Contention: the requester that was not served last wins
          grant_valid = 1'b1;
          grant_id    = ~last_id_reg;
        end else if (req0_valid) begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end else if (req1_valid) begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        if (grant_valid) begin
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Readies are combinational; the reset term keeps them low while rst is
  // held even though the state register already reads IDLE.
  assign req0_ready = grant_valid && !grant_id && !rst;
  assign req1_ready = grant_valid &&  grant_id && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_a_reg     <= 4'd0;
      op_b_reg     <= 4'd0;
      op_code_reg  <= 3'd0;
      cur_id_reg   <= 1'b0;
      last_id_reg  <= 1'b1;
      rsp_data_reg <= 4'd0;
      rsp_id_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_valid) begin
        op_a_reg    <= grant_id ? req1_a  : req0_a;
        op_b_reg    <= grant_id ? req1_b  : req0_b;
        op_code_reg <= grant_id ? req1_op : req0_op;
        cur_id_reg  <= grant_id;
      end
      if (state_reg == EXEC) begin
        rsp_data_reg <= alu_out;
        rsp_id_reg   <= cur_id_reg;
        last_id_reg  <= cur_id_reg;
      end
    end
  end

  // ALU inputs are zeroed outside EXEC so the ALU idles at output 0; since
  // they derive from the state register they clear immediately on reset.
  assign alu_a  = (state_reg == EXEC) ? op_a_reg    : 4'd0;
  assign alu_b  = (state_reg == EXEC) ? op_b_reg    : 4'd0;
  assign alu_op = (state_reg == EXEC) ? op_code_reg : 3'd0;

  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = (state_reg != IDLE);

endmodule
